ptp_rx_arbiter: RTL
===================

Name: ptp_rx_arbiter

Overview:
- Round-robin packet arbiter that merges up to N_PORT per-port PTP receive streams into the single 134-bit PTP receive input of the RX processing block.
- The output carries the data word, data write, per-packet valid write, valid flag, and back-pressure.
- Grants one whole packet at a time, forwards it with one cycle of registered latency, and aborts stalled packets by timeout so the downstream FIFOs never hold a partial packet.

Parameters:
- N_PORT, 4, number of requesting ports (2..8)
- W_PKT, 134, packet word width; bits [133:132] are the frame flag: 01 head, 00 middle, 10 tail
- TIMEOUT, 255, consecutive idle cycles in transfer before abort (1..65535)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-low reset
- port_req  in  N_PORT  port i has a complete packet ready to send
- port_gnt  out  N_PORT  one-hot grant, held for the whole packet
- port_data_wr  in  N_PORT  word strobe per port
- port_data  in  N_PORT*W_PKT  port i word at [i*W_PKT +: W_PKT]
- port_valid_wr  in  N_PORT  per-packet valid strobe, coincident with the tail word
- port_valid  in  N_PORT  1 = keep packet, 0 = discard
- inptp_data_wr  out  1  word strobe to RX
- inptp_data  out  W_PKT  word to RX
- inptp_valid_wr  out  1  valid strobe to RX
- inptp_valid  out  1  valid flag to RX
- inptp_ready  in  1  RX data FIFO has room for at least one maximum-size packet
- pkt_cnt  out  32  packets forwarded with a real tail
- abort_cnt  out  32  packets aborted by timeout
- err_cnt  out  32  strobes from non-granted ports

Behaviour:
- Reset (async, low): all outputs 0; state IDLE; rr_ptr = N_PORT-1 so port 0 wins first; idle counter 0. Reset mid-packet drops the packet silently with no tail emitted.
- States: IDLE, XFER.
- IDLE:
  - Output strobes are 0.
  - If inptp_ready=1 and port_req!=0, select the first requesting port searching from rr_ptr+1 modulo N_PORT.
  - Register port_gnt one-hot and rr_ptr = winner; go to XFER.
  - Grant is visible one cycle after the request is sampled.
  - inptp_ready is sampled only here, never mid-packet.
- XFER (granted port g):
  - Each cycle: inptp_data_wr <= port_data_wr[g], inptp_data <= port_data[g], inptp_valid_wr <= port_valid_wr[g], inptp_valid <= port_valid[g]. Latency is 1 cycle.
  - When inptp_data_wr is low, inptp_data holds its previous value.
  - Tail: when port_data_wr[g]=1 and flag==10, then next cycle port_gnt=0, state=IDLE, pkt_cnt+1.
  - Minimum gap between packets is one IDLE cycle; the next grant is visible 2 cycles after the tail is sampled.
  - Idle counter:
    - Resets to 0 on any port_data_wr[g].
    - Increments otherwise.
    - On reaching TIMEOUT, the next cycle outputs inptp_data_wr=1, inptp_data={2'b10,132'b0}, inptp_valid_wr=1, inptp_valid=0; also port_gnt=0, state=IDLE, abort_cnt+1.
    - A tail arriving in the same cycle as timeout wins: it is a normal tail and no abort is issued.
- Non-granted strobes: port_data_wr or port_valid_wr from any port != g, or any port in IDLE, is dropped and never forwarded. err_cnt +1 per cycle in which any such strobe occurs.
- Requests arriving during XFER wait; port_req may stay high across back-to-back packets. Round-robin guarantees each requester is served within N_PORT grants.
- Counters are 32-bit and wrap modulo 2^32.
- The flag is not otherwise checked: a head word inside a packet is forwarded unchanged.
- Implementation: synchronous, single clock.

Test Plan:
- Single port 0: req with ready=1; send 4 words flags 01,00,00,10 with valid_wr/valid=1 on the tail -> gnt[0] rises 1 cycle after req; identical words appear 1 cycle later; gnt drops after tail; pkt_cnt=1.
- Ports 0,1,2 requesting continuously, 3-word packets each -> grant order 0,1,2,0,1,2; one IDLE cycle between packets; pkt_cnt=6.
- inptp_ready=0 with req pending for 10 cycles -> no grant; on ready=1, grant next cycle. Dropping ready mid-packet does not interrupt it.
- TIMEOUT=8: granted port sends head then stalls -> after 8 idle cycles, one word {10,0} with valid_wr=1 and valid=0 emitted; gnt=0; abort_cnt=1; pkt_cnt unchanged.
- Port 3 strobes data_wr while port 1 is granted -> nothing from port 3 is forwarded; err_cnt increments per cycle; port 1 stream is unaffected.
- Assert reset mid-XFER -> all outputs 0 immediately; after release, port 0 has priority and the next packet forwards cleanly.

Source files
------------

// File: rtl/ptp_rx_arbiter.sv
// Round-robin packet arbiter merging N_PORT PTP receive streams into one RX input.
// Whole packets are granted, forwarded with one registered cycle, and aborted on stall.
module ptp_rx_arbiter #(
    parameter int N_PORT  = 4,
    parameter int W_PKT   = 134,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_PORT-1:0]       port_req,
    output logic [N_PORT-1:0]       port_gnt,
    input  logic [N_PORT-1:0]       port_data_wr,
    input  logic [N_PORT*W_PKT-1:0] port_data,
    input  logic [N_PORT-1:0]       port_valid_wr,
    input  logic [N_PORT-1:0]       port_valid,
    output logic                    inptp_data_wr,
    output logic [W_PKT-1:0]        inptp_data,
    output logic                    inptp_valid_wr,
    output logic                    inptp_valid,
    input  logic                    inptp_ready,
    output logic [31:0]             pkt_cnt,
    output logic [31:0]             abort_cnt,
    output logic [31:0]             err_cnt
);

    localparam int PW = (N_PORT > 1) ? $clog2(N_PORT) : 1;
    localparam int IW = 16;
    localparam logic [1:0] FLAG_TAIL = 2'b10;

    typedef enum logic {
        IDLE,
        XFER
    } state_t;

    state_t            state_q, state_d;
    logic [N_PORT-1:0] gnt_q, gnt_d;
    logic [PW-1:0]     rr_q, rr_d;
    logic [IW-1:0]     idle_q, idle_d;
    logic              dwr_q, dwr_d;
    logic [W_PKT-1:0]  data_q, data_d;
    logic              vwr_q, vwr_d;
    logic              vld_q, vld_d;
    logic [31:0]       pkt_q, pkt_d;
    logic [31:0]       abort_q, abort_d;
    logic [31:0]       err_q, err_d;

    // rr_q doubles as the index of the granted port while in XFER.
    logic              sel_dwr;
    logic              sel_vwr;
    logic              sel_vld;
    logic [W_PKT-1:0]  sel_data;
    logic              sel_tail;

    assign sel_dwr  = port_data_wr[rr_q];
    assign sel_vwr  = port_valid_wr[rr_q];
    assign sel_vld  = port_valid[rr_q];
    assign sel_data = port_data[int'(rr_q)*W_PKT +: W_PKT];
    assign sel_tail = sel_dwr && (sel_data[W_PKT-1 -: 2] == FLAG_TAIL);

    logic [PW-1:0] win;
    logic          win_found;
    int            win_idx;

    always_comb begin
        win       = rr_q;
        win_found = 1'b0;
        win_idx   = 0;
        for (int off = 1; off <= N_PORT; off++) begin
            win_idx = (int'(rr_q) + off) % N_PORT;
            if (!win_found && port_req[win_idx]) begin
                win_found = 1'b1;
                win       = PW'(win_idx);
            end
        end
    end

    logic [N_PORT-1:0] allowed;
    logic              stray;

    assign allowed = (state_q == XFER) ? gnt_q : '0;
    assign stray   = |((port_data_wr | port_valid_wr) & ~allowed);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        idle_d  = idle_q;
        dwr_d   = 1'b0;
        data_d  = data_q;
        vwr_d   = 1'b0;
        vld_d   = vld_q;
        pkt_d   = pkt_q;
        abort_d = abort_q;
        err_d   = err_q + 32'(stray);

        case (state_q)
            IDLE: begin
                if (inptp_ready && win_found) begin
                    gnt_d       = '0;
                    gnt_d[win]  = 1'b1;
                    rr_d        = win;
                    idle_d      = '0;
                    state_d     = XFER;
                end
            end
            XFER: begin
                dwr_d = sel_dwr;
                vwr_d = sel_vwr;
                vld_d = sel_vld;
                if (sel_dwr) begin
                    data_d = sel_data;
                end
                // A tail in the timeout cycle still closes the packet normally.
                if (sel_tail) begin
                    gnt_d   = '0;
                    state_d = IDLE;
                    pkt_d   = pkt_q + 32'd1;
                    idle_d  = '0;
                end else if (idle_q == IW'(TIMEOUT)) begin
                    dwr_d   = 1'b1;
                    data_d  = {FLAG_TAIL, {(W_PKT-2){1'b0}}};
                    vwr_d   = 1'b1;
                    vld_d   = 1'b0;
                    gnt_d   = '0;
                    state_d = IDLE;
                    abort_d = abort_q + 32'd1;
                    idle_d  = '0;
                end else if (sel_dwr) begin
                    idle_d = '0;
                end else begin
                    idle_d = idle_q + IW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            rr_q    <= PW'(N_PORT - 1);
            idle_q  <= '0;
            dwr_q   <= 1'b0;
            data_q  <= '0;
            vwr_q   <= 1'b0;
            vld_q   <= 1'b0;
            pkt_q   <= '0;
            abort_q <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            idle_q  <= idle_d;
            dwr_q   <= dwr_d;
            data_q  <= data_d;
            vwr_q   <= vwr_d;
            vld_q   <= vld_d;
            pkt_q   <= pkt_d;
            abort_q <= abort_d;
            err_q   <= err_d;
        end
    end

    assign port_gnt       = gnt_q;
    assign inptp_data_wr  = dwr_q;
    assign inptp_data     = data_q;
    assign inptp_valid_wr = vwr_q;
    assign inptp_valid    = vld_q;
    assign pkt_cnt        = pkt_q;
    assign abort_cnt      = abort_q;
    assign err_cnt        = err_q;

endmodule
